// File: rtl/elevator_motion_ctrl.sv
// Car motion controller: latches floor calls, runs SCAN up/down travel with a door dwell,
// and publishes movement state, current floor and a refresh strobe for the LCD status page.
module elevator_motion_ctrl #(
    parameter int N_FLOORS    = 4,
    parameter int FLOOR_TICKS = 50_000_000,
    parameter int DOOR_TICKS  = 100_000_000,
    localparam int FW = $clog2(N_FLOORS)
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    input  logic [N_FLOORS-1:0] iCALL,
    output logic [1:0]          oMOVE,
    output logic [FW-1:0]       oFLOOR,
    output logic                oDOOR_OPEN,
    output logic [N_FLOORS-1:0] oPENDING,
    output logic                oUPDATE
);
    localparam int TW = $clog2(FLOOR_TICKS);
    localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(FLOOR_TICKS - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_TICKS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UP     = 3'd1;
    localparam logic [2:0] S_DOWN   = 3'd2;
    localparam logic [2:0] S_ARRIVE = 3'd3;
    localparam logic [2:0] S_DOOR   = 3'd4;

    localparam logic [1:0] MV_STOP = 2'd0;
    localparam logic [1:0] MV_UP   = 2'd1;
    localparam logic [1:0] MV_DOWN = 2'd2;

    logic [2:0]          state, stateNext, decision;
    logic                lastDirUp, lastDirNext, startup;
    logic [TW-1:0]       travelCnt, travelNext;
    logic [DW-1:0]       doorCnt, doorCntNext;
    logic [1:0]          moveNext;
    logic [FW-1:0]       floorNext;
    logic                doorNext;
    logic [N_FLOORS-1:0] floorHot, aboveVec, belowVec, callIn, clr, pendingNext;
    logic                above, below, hereCall, herePending, applyDecision;

    generate
        for (genvar gi = 0; gi < N_FLOORS; gi++) begin : gFloor
            assign floorHot[gi] = (oFLOOR == FW'(gi));
            assign aboveVec[gi] = oPENDING[gi] && (FW'(gi) > oFLOOR);
            assign belowVec[gi] = oPENDING[gi] && (FW'(gi) < oFLOOR);
        end
    endgenerate

    assign above       = |aboveVec;
    assign below       = |belowVec;
    assign herePending = |(oPENDING & floorHot);
    assign hereCall    = |(iCALL & floorHot);

    // A call for the floor whose door is already open just holds the door; it is never latched.
    assign callIn      = (state == S_DOOR) ? (iCALL & ~floorHot) : iCALL;
    assign pendingNext = (oPENDING | callIn) & ~clr;

    // SCAN: keep the last direction while targets remain ahead, otherwise reverse.
    always_comb begin
        decision = S_IDLE;
        if (herePending)
            decision = S_DOOR;
        else if (lastDirUp) begin
            if (above)      decision = S_UP;
            else if (below) decision = S_DOWN;
        end else begin
            if (below)      decision = S_DOWN;
            else if (above) decision = S_UP;
        end
    end

    always_comb begin
        stateNext     = state;
        moveNext      = oMOVE;
        floorNext     = oFLOOR;
        doorNext      = oDOOR_OPEN;
        travelNext    = travelCnt;
        doorCntNext   = doorCnt;
        lastDirNext   = lastDirUp;
        clr           = '0;
        applyDecision = 1'b0;

        case (state)
            S_IDLE, S_ARRIVE: applyDecision = 1'b1;
            S_UP, S_DOWN: begin
                if (travelCnt == TRAVEL_LAST) begin
                    floorNext  = (state == S_UP) ? oFLOOR + 1'b1 : oFLOOR - 1'b1;
                    travelNext = '0;
                    stateNext  = S_ARRIVE;
                end else begin
                    travelNext = travelCnt + 1'b1;
                end
            end
            S_DOOR: begin
                if (hereCall)
                    doorCntNext = '0;
                else if (doorCnt == DOOR_LAST)
                    applyDecision = 1'b1;
                else
                    doorCntNext = doorCnt + 1'b1;
            end
            default: stateNext = S_IDLE;
        endcase

        if (applyDecision) begin
            stateNext = decision;
            case (decision)
                S_DOOR: begin
                    moveNext    = MV_STOP;
                    doorNext    = 1'b1;
                    doorCntNext = '0;
                    clr         = floorHot;
                end
                S_UP: begin
                    moveNext    = MV_UP;
                    doorNext    = 1'b0;
                    travelNext  = '0;
                    lastDirNext = 1'b1;
                end
                S_DOWN: begin
                    moveNext    = MV_DOWN;
                    doorNext    = 1'b0;
                    travelNext  = '0;
                    lastDirNext = 1'b0;
                end
                default: begin
                    moveNext = MV_STOP;
                    doorNext = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= S_IDLE;
            lastDirUp  <= 1'b1;
            travelCnt  <= '0;
            doorCnt    <= '0;
            startup    <= 1'b1;
            oMOVE      <= MV_STOP;
            oFLOOR     <= '0;
            oDOOR_OPEN <= 1'b0;
            oPENDING   <= '0;
            oUPDATE    <= 1'b0;
        end else begin
            state      <= stateNext;
            lastDirUp  <= lastDirNext;
            travelCnt  <= travelNext;
            doorCnt    <= doorCntNext;
            startup    <= 1'b0;
            oMOVE      <= moveNext;
            oFLOOR     <= floorNext;
            oDOOR_OPEN <= doorNext;
            oPENDING   <= pendingNext;
            // Door-only changes deliberately do not request a redraw.
            oUPDATE    <= startup | (moveNext != oMOVE) | (floorNext != oFLOOR);
        end
    end
endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Directed bench for elevator_motion_ctrl with short floor/door timing (4 floors, 4/6 ticks).
module tb_elevator_motion_ctrl;
    localparam int NF = 4;
    localparam int FT = 4;
    localparam int DT = 6;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic [3:0] iCALL = 4'b0000;
    logic [1:0] oMOVE;
    logic [1:0] oFLOOR;
    logic       oDOOR_OPEN;
    logic [3:0] oPENDING;
    logic       oUPDATE;

    int assertCnt = 0;
    int failCnt   = 0;
    int updCnt, updMask, doorCycles, stopLog, sawDown, sawMove3, pendSeen, prevDoor, moved;

    always #5 iCLK = ~iCLK;

    elevator_motion_ctrl #(
        .N_FLOORS   (NF),
        .FLOOR_TICKS(FT),
        .DOOR_TICKS (DT)
    ) dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iCALL     (iCALL),
        .oMOVE     (oMOVE),
        .oFLOOR    (oFLOOR),
        .oDOOR_OPEN(oDOOR_OPEN),
        .oPENDING  (oPENDING),
        .oUPDATE   (oUPDATE)
    );

    task automatic checkResult(input string tag, input int got, input int exp);
        assertCnt++;
        if (got != exp) begin
            failCnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance n rising edges, then park on the falling edge for sampling/driving.
    task automatic edges(input int n);
        repeat (n) @(posedge iCLK);
        @(negedge iCLK);
    endtask

    task automatic doReset();
        iRST_N = 1'b0;
        edges(2);
        iRST_N = 1'b1;
        edges(2);
    endtask

    initial begin
        // 1. Startup
        iRST_N = 1'b0;
        iCALL  = 4'b0000;
        edges(2);
        checkResult("rst_move",    oMOVE, 0);
        checkResult("rst_floor",   oFLOOR, 0);
        checkResult("rst_door",    oDOOR_OPEN, 0);
        checkResult("rst_pending", oPENDING, 0);
        checkResult("rst_update",  oUPDATE, 0);
        iRST_N = 1'b1;
        edges(1);
        checkResult("startup_update", oUPDATE, 1);
        checkResult("startup_move",   oMOVE, 0);
        checkResult("startup_floor",  oFLOOR, 0);
        checkResult("startup_door",   oDOOR_OPEN, 0);
        updCnt = 0;
        repeat (5) begin
            edges(1);
            updCnt += int'(oUPDATE);
        end
        checkResult("startup_update_quiet", updCnt, 0);

        // 2. Single trip floor 0 -> 2
        iCALL = 4'b0100;
        edges(1);
        iCALL = 4'b0000;
        checkResult("t2_pending_e0", oPENDING, 4);
        checkResult("t2_move_e0",    oMOVE, 0);
        updMask = 0;
        for (int k = 1; k <= 17; k++) begin
            edges(1);
            if (oUPDATE) updMask |= (1 << k);
            if (k == 1)  checkResult("t2_move_e1",    oMOVE, 1);
            if (k == 4)  checkResult("t2_floor_e4",   oFLOOR, 0);
            if (k == 5)  checkResult("t2_floor_e5",   oFLOOR, 1);
            if (k == 9)  checkResult("t2_floor_e9",   oFLOOR, 1);
            if (k == 10) checkResult("t2_floor_e10",  oFLOOR, 2);
            if (k == 10) checkResult("t2_move_e10",   oMOVE, 1);
            if (k == 11) checkResult("t2_move_e11",   oMOVE, 0);
            if (k == 11) checkResult("t2_door_e11",   oDOOR_OPEN, 1);
            if (k == 11) checkResult("t2_pending_e11", oPENDING, 0);
            if (k == 16) checkResult("t2_door_e16",   oDOOR_OPEN, 1);
            if (k == 17) checkResult("t2_door_e17",   oDOOR_OPEN, 0);
        end
        checkResult("t2_update_mask", updMask, 32'h0000_0C22);

        // 3. Call at current floor while idle at floor 2
        iCALL = 4'b0100;
        edges(1);
        iCALL = 4'b0000;
        edges(1);
        checkResult("t3_door_e1",    oDOOR_OPEN, 1);
        checkResult("t3_move_e1",    oMOVE, 0);
        checkResult("t3_pending_e1", oPENDING, 0);
        doorCycles = 1;
        updCnt = int'(oUPDATE);
        repeat (10) begin
            edges(1);
            doorCycles += int'(oDOOR_OPEN);
            updCnt += int'(oUPDATE);
            if (oMOVE != 2'd0) updCnt += 100;
        end
        checkResult("t3_door_cycles", doorCycles, 6);
        checkResult("t3_no_update",   updCnt, 0);

        // 4. SCAN ordering: up to 3 first, then down to 0 without intermediate stops
        doReset();
        iCALL = 4'b1000;
        edges(1);
        iCALL = 4'b0000;
        edges(5);
        checkResult("t4_floor_e5", oFLOOR, 1);
        checkResult("t4_move_e5",  oMOVE, 1);
        iCALL = 4'b0001;
        edges(1);
        iCALL = 4'b0000;
        checkResult("t4_pending", oPENDING, 9);
        stopLog = 0; sawDown = 0; sawMove3 = 0; prevDoor = 0;
        repeat (45) begin
            edges(1);
            if (oDOOR_OPEN && !prevDoor) stopLog = stopLog * 10 + int'(oFLOOR) + 1;
            if (oMOVE == 2'd2 && stopLog == 4) sawDown = 1;
            if (oMOVE == 2'd3) sawMove3 = 1;
            prevDoor = int'(oDOOR_OPEN);
        end
        checkResult("t4_stop_order", stopLog, 41);
        checkResult("t4_saw_down",   sawDown, 1);
        checkResult("t4_no_move3",   sawMove3, 0);
        checkResult("t4_final_floor", oFLOOR, 0);
        checkResult("t4_final_pending", oPENDING, 0);

        // 5. Door restart at floor 1
        iCALL = 4'b0010;
        edges(1);
        iCALL = 4'b0000;
        edges(6);
        checkResult("t5_door_open", oDOOR_OPEN, 1);
        checkResult("t5_floor",     oFLOOR, 1);
        edges(3);
        iCALL = 4'b0010;
        edges(1);
        iCALL = 4'b0000;
        pendSeen = int'(oPENDING[1]);
        doorCycles = int'(oDOOR_OPEN);
        repeat (10) begin
            edges(1);
            doorCycles += int'(oDOOR_OPEN);
            pendSeen |= int'(oPENDING[1]);
        end
        checkResult("t5_door_cycles", doorCycles, 6);
        checkResult("t5_pending1",    pendSeen, 0);

        // 6. Asynchronous reset mid-travel
        doReset();
        iCALL = 4'b1000;
        edges(1);
        iCALL = 4'b0000;
        edges(6);
        checkResult("t6_move_pre",    oMOVE, 1);
        checkResult("t6_floor_pre",   oFLOOR, 1);
        checkResult("t6_pending_pre", oPENDING, 8);
        #2 iRST_N = 1'b0;
        #1;
        checkResult("t6_async_move",    oMOVE, 0);
        checkResult("t6_async_floor",   oFLOOR, 0);
        checkResult("t6_async_pending", oPENDING, 0);
        checkResult("t6_async_door",    oDOOR_OPEN, 0);
        checkResult("t6_async_update",  oUPDATE, 0);
        @(negedge iCLK);
        edges(2);
        iRST_N = 1'b1;
        edges(1);
        checkResult("t6_startup_update", oUPDATE, 1);
        moved = 0;
        repeat (10) begin
            edges(1);
            if (oMOVE != 2'd0 || oFLOOR != 2'd0 || oPENDING != 4'd0) moved = 1;
        end
        checkResult("t6_idle_after", moved, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end
endmodule

// File: doc/elevator_motion_ctrl.md
Name: elevator_motion_ctrl

Overview:
- Upstream stage of the LCD status page. Latches floor calls, runs the car movement state machine with SCAN direction logic, and times floor travel and door dwell.
- Publishes movement state (0 parado, 1 subindo, 2 descendo) and the current floor, plus a one-cycle refresh strobe. The LCD message sequencer consumes these to pick and redraw its text.

Parameters:
- N_FLOORS, 4, number of floors; must be ≥2; floors are numbered 0..N_FLOORS-1.
- FLOOR_TICKS, 50_000_000, clock cycles to travel one floor; must be ≥2.
- DOOR_TICKS, 100_000_000, clock cycles the door stays open; must be ≥1.
- FW, $clog2(N_FLOORS), floor index width (derived, not overridden).

Ports:
- iCLK  in  1  system clock; single clock domain.
- iRST_N  in  1  asynchronous, active-low reset.
- iCALL  in  N_FLOORS  call request per floor; a level or pulse is sampled every edge.
- oMOVE  out  2  0 = parado, 1 = subindo, 2 = descendo; 3 is never driven.
- oFLOOR  out  FW  current floor.
- oDOOR_OPEN  out  1  door open.
- oPENDING  out  N_FLOORS  latched, unserved calls.
- oUPDATE  out  1  one-cycle strobe requesting an LCD refresh.

Behaviour:
- Clocking and reset: one clock (iCLK). Reset is asynchronous, active-low (iRST_N). All state is registered.
- Reset values: oMOVE = 0, oFLOOR = 0, oDOOR_OPEN = 0, oPENDING = 0, oUPDATE = 0. Internally: state = IDLE, last_dir = up, travel and door counters = 0, startup flag = 1.
- Reset is asserted asynchronously mid-operation. Release is sampled on the clock.
- Call latch: every edge, pending <= (pending | iCALL) & ~clr. clr is the current-floor bit on the edge that enters DOOR, and only that edge. A call to the current floor while in DOOR is absorbed (not latched) and restarts the door counter at 0.
- Direction terms: above = any pending bit at an index > oFLOOR; below = any pending bit at an index < oFLOOR.
- Decision rule, applied in IDLE, ARRIVE, and at DOOR expiry:
  - pending[oFLOOR] set → DOOR.
  - Otherwise, if last_dir = up: above → UP; else below → DOWN; else IDLE.
  - If last_dir = down: the same rule with above and below swapped.
  - Entering UP sets last_dir = up; entering DOWN sets last_dir = down.
- States:
  - IDLE: oMOVE = 0. Applies the decision rule on every edge.
  - UP / DOWN: oMOVE = 1 / 2. The travel counter counts 0..FLOOR_TICKS-1. On the edge where the counter equals FLOOR_TICKS-1: oFLOOR is incremented (UP) or decremented (DOWN), the counter clears, and the state goes to ARRIVE.
  - ARRIVE: lasts exactly one cycle; oMOVE is held. Applies the decision rule. UP→UP or DOWN→DOWN continues with the counter at 0 and no oMOVE change.
  - DOOR: oMOVE = 0, oDOOR_OPEN = 1. The door counter counts 0..DOOR_TICKS-1; on the edge at DOOR_TICKS-1 it applies the decision rule (→ IDLE, UP, DOWN, or DOOR again).
- Timing:
  - One floor of travel = FLOOR_TICKS cycles in UP/DOWN plus 1 ARRIVE cycle.
  - Door open time = DOOR_TICKS cycles, unless restarted.
- Boundaries:
  - oFLOOR never wraps. UP is never entered at floor N_FLOORS-1 and DOWN is never entered at floor 0, because the decision rule guarantees a target lies beyond.
  - Calls arriving during travel are latched. A call at a floor not yet passed is served on arrival at that floor; a call behind the car waits for the reversal.
- oUPDATE:
  - Registered; high in exactly the cycle in which a new oMOVE or oFLOOR value first becomes visible.
  - Also high for the first cycle after reset release (startup flag, then cleared).
  - Not asserted for door-only events.
- Latency: a call sampled on edge E0 in IDLE sets pending after E0; oMOVE changes after E1.

Test Plan:
All scenarios use N_FLOORS = 4, FLOOR_TICKS = 4, DOOR_TICKS = 6, with E0 = the edge that samples iCALL.
1. Startup: release reset with no calls → oMOVE = 0, oFLOOR = 0, oDOOR_OPEN = 0; oUPDATE high for exactly the first cycle after release, then stays low.
2. Single trip: at floor 0, pulse iCALL = 4'b0100 → oPENDING = 0100 after E0; oMOVE = 1 after E1; oFLOOR = 1 after E5; oFLOOR = 2 after E10; oMOVE = 0, oDOOR_OPEN = 1, oPENDING = 0 after E11; door closes after E17; oUPDATE pulses after E1, E5, E10, E11 only.
3. Call at current floor while IDLE at floor 2 (iCALL = 0100) → DOOR after E1; oMOVE stays 0; oDOOR_OPEN high for 6 cycles; no oUPDATE.
4. SCAN ordering: car moving up from floor 0 toward floor 3 (iCALL = 1000); call floor 0 while oFLOOR = 1 → car stops at floor 3 (door), then oMOVE = 2, reaching floor 0 with no stops at floors 2 or 1.
5. Door restart: during DOOR at floor 1 at door count 3, assert iCALL = 0010 → counter restarts; oDOOR_OPEN stays high 6 more cycles; oPENDING[1] stays 0.
6. Asynchronous reset mid-travel (oMOVE = 1, oFLOOR = 1, oPENDING = 1000): drop iRST_N between edges → all outputs go to reset values immediately, without a clock edge; after release the car idles at floor 0.
